// File: rtl/rf_dump_tx.sv
// rtl/rf_dump_tx.sv - register-file dump engine emitting ASCII hex lines on a byte stream
`timescale 1ns/1ps
module rf_dump_tx #(
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, FETCH, HEX, SEP, LF, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        nib_q, nib_d;
    logic [31:0]       shift_q, shift_d;
    logic              last_col;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign last_col = ((int'(idx_q) % PER_LINE) == (PER_LINE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            nib_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            nib_q   <= nib_d;
            shift_q <= shift_d;
        end
    end

    // Stream outputs are decoded from state so reset clears them without waiting for a clock.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        nib_d    = nib_q;
        shift_d  = shift_q;
        rd_addr  = addr_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = (state_q != IDLE) && (state_q != DONE);
        done     = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                rd_addr = idx_q;
                addr_d  = idx_q;
                shift_d = rd_data;
                nib_d   = '0;
                state_d = HEX;
            end
            HEX: begin
                tx_valid = 1'b1;
                tx_data  = hex_ascii(shift_q[31:28]);
                if (tx_ready) begin
                    shift_d = {shift_q[27:0], 4'h0};
                    nib_d   = nib_q + 3'd1;
                    if (nib_q == 3'd7) begin
                        state_d = SEP;
                    end
                end
            end
            SEP: begin
                tx_valid = 1'b1;
                tx_data  = last_col ? 8'h0D : 8'h20;
                if (tx_ready) begin
                    if (last_col) begin
                        state_d = LF;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            LF: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
        end
    end

endmodule
